// File: rtl/tmr_match_scheduler_v1.sv
// Timer match scheduler: on each match0 event, pops a delta from a small queue,
// adds it to the last programmed match value and writes the sum to the timer
// MVAL0 register over the shared timer SFR bus, stalling the CPU for that cycle.
module tmr_match_scheduler_v1 #(
   parameter int                    DATA_WIDTH      = 32,
   parameter int                    ADDR_WIDTH      = 32,
   parameter logic [ADDR_WIDTH-1:0] TMR_BASE_ADDR   = '0,
   parameter logic [ADDR_WIDTH-1:0] SCHED_BASE_ADDR = 'h100,
   parameter int                    FIFO_DEPTH      = 8
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   input  logic                  sys_clk_en,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic                  cpu_wr_en,
   input  logic [DATA_WIDTH-1:0] cpu_wr_data,
   output logic                  cpu_stall,
   output logic [DATA_WIDTH-1:0] sched_rd_dout,
   input  logic                  match0_event,
   output logic [ADDR_WIDTH-1:0] sys_addr,
   output logic                  sys_wr_en,
   output logic [DATA_WIDTH-1:0] sys_sw_value
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   localparam logic [ADDR_WIDTH-1:0] MVAL0_ADDR = TMR_BASE_ADDR + ADDR_WIDTH'(8);
   localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR  = SCHED_BASE_ADDR;
   localparam logic [ADDR_WIDTH-1:0] PUSH_ADDR  = SCHED_BASE_ADDR + ADDR_WIDTH'(4);
   localparam logic [ADDR_WIDTH-1:0] STAT_ADDR  = SCHED_BASE_ADDR + ADDR_WIDTH'(8);

   typedef enum logic [1:0] {
      S_IDLE,
      S_POP,
      S_WRITE
   } state_t;

   state_t                state, state_nx;
   logic                  en;
   logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr, rd_ptr;
   logic [CNT_W-1:0]      count;
   logic [DATA_WIDTH-1:0] match_shadow, next_q;
   logic                  pending, pending_nx;
   logic                  event_d;
   logic                  undr, ovf, lost;
   logic                  set_undr, set_lost;
   logic                  do_pop, do_push;

   // A CPU access during the scheduler's bus write is stalled and repeated,
   // so it must not have any side effect in the stalled cycle.
   assign cpu_stall = (state == S_WRITE);

   logic cpu_wr_ok;
   assign cpu_wr_ok = cpu_wr_en & ~cpu_stall;

   logic wr_ctrl, wr_push, wr_stat, wr_mval0, flush;
   assign wr_ctrl  = cpu_wr_ok & (cpu_addr == CTRL_ADDR);
   assign wr_push  = cpu_wr_ok & (cpu_addr == PUSH_ADDR);
   assign wr_stat  = cpu_wr_ok & (cpu_addr == STAT_ADDR);
   assign wr_mval0 = cpu_wr_ok & (cpu_addr == MVAL0_ADDR);
   assign flush    = wr_ctrl & cpu_wr_data[1];

   logic full, empty, edge_det;
   assign full     = (count == CNT_W'(FIFO_DEPTH));
   assign empty    = (count == '0);
   assign edge_det = match0_event & ~event_d;
   // A push into a full queue is rejected even if a pop frees a slot this cycle.
   assign do_push  = wr_push & ~full & ~flush;

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of block ordering.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state <= S_IDLE;
      end else if (sys_clk_en) begin
         state <= state_nx;
      end
   end

   // Next state, event bookkeeping and timer bus mux.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch.
      state_nx     = state;
      pending_nx   = pending;
      set_undr     = 1'b0;
      set_lost     = 1'b0;
      do_pop       = 1'b0;
      sys_addr     = cpu_addr;
      sys_wr_en    = cpu_wr_en;
      sys_sw_value = cpu_wr_data;

      // While a delta is in flight, an edge is remembered once; a second is lost.
      if (state != S_IDLE && edge_det) begin
         if (pending) set_lost = 1'b1;
         else         pending_nx = 1'b1;
      end

      case (state)
         S_IDLE: begin
            if (en && !flush && (edge_det || pending)) begin
               if (edge_det && pending) set_lost = 1'b1;
               pending_nx = 1'b0;
               if (!empty) state_nx = S_POP;
               else        set_undr = 1'b1;
            end
         end
         S_POP: begin
            do_pop   = 1'b1;
            state_nx = S_WRITE;
         end
         S_WRITE: begin
            sys_addr     = MVAL0_ADDR;
            sys_wr_en    = 1'b1;
            sys_sw_value = next_q;
            state_nx     = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase

      if (flush || !en) pending_nx = 1'b0;
   end

   // Queue storage.
   // NOTE: the storage array has no reset; occupancy is tracked by the
   // pointers and count, so stale entries are never observed.
   always_ff @(posedge sys_clk) begin
      if (sys_clk_en && do_push) begin
         fifo_mem[wr_ptr] <= cpu_wr_data;
      end
   end

   // Queue pointers and occupancy; FLUSH overrides push and pop.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (sys_clk_en) begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
         end
      end
   end

   // Match value computation and shadow of the last value written to MVAL0.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         next_q       <= '0;
         match_shadow <= '0;
      end else if (sys_clk_en) begin
         if (state == S_POP) next_q <= match_shadow + fifo_mem[rd_ptr];
         if (state == S_WRITE)  match_shadow <= next_q;
         else if (wr_mval0)     match_shadow <= cpu_wr_data;
      end
   end

   // Control, event history and sticky status; a new set beats a clear.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         en      <= 1'b0;
         event_d <= 1'b0;
         pending <= 1'b0;
         undr    <= 1'b0;
         ovf     <= 1'b0;
         lost    <= 1'b0;
      end else if (sys_clk_en) begin
         if (wr_ctrl) en <= cpu_wr_data[0];
         event_d <= match0_event;
         pending <= pending_nx;
         undr    <= set_undr | (undr & ~(wr_stat & cpu_wr_data[10]));
         ovf     <= (wr_push & full) | (ovf & ~(wr_stat & cpu_wr_data[11]));
         lost    <= set_lost | (lost & ~(wr_stat & cpu_wr_data[12]));
      end
   end

   // Read data for the wired-OR SFR read bus.
   always_comb begin
      sched_rd_dout = '0;
      if (cpu_addr == CTRL_ADDR) begin
         sched_rd_dout[0] = en;
      end else if (cpu_addr == STAT_ADDR) begin
         sched_rd_dout[12:0] = {lost, ovf, undr, empty, full, 8'(count)};
      end
   end

endmodule

// File: tb/tb_tmr_match_scheduler_v1.sv
// Randomized scoreboard bench for tmr_match_scheduler_v1 with a queue-based
// reference model of the delta queue, shadow value and status flags.
module tb_tmr_match_scheduler_v1;

   localparam int          DEPTH   = 8;
   localparam logic [31:0] A_MVAL0 = 32'h0000_0008;
   localparam logic [31:0] A_CTRL  = 32'h0000_0100;
   localparam logic [31:0] A_PUSH  = 32'h0000_0104;
   localparam logic [31:0] A_STAT  = 32'h0000_0108;
   localparam logic [31:0] A_IDLE  = 32'h0000_0F00;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        sys_clk_en = 1'b1;
   logic [31:0] cpu_addr = A_IDLE;
   logic        cpu_wr_en = 1'b0;
   logic [31:0] cpu_wr_data = '0;
   logic        cpu_stall;
   logic [31:0] sched_rd_dout;
   logic        match0_event = 1'b0;
   logic [31:0] sys_addr;
   logic        sys_wr_en;
   logic [31:0] sys_sw_value;

   tmr_match_scheduler_v1 dut (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .sys_clk_en   (sys_clk_en),
      .cpu_addr     (cpu_addr),
      .cpu_wr_en    (cpu_wr_en),
      .cpu_wr_data  (cpu_wr_data),
      .cpu_stall    (cpu_stall),
      .sched_rd_dout(sched_rd_dout),
      .match0_event (match0_event),
      .sys_addr     (sys_addr),
      .sys_wr_en    (sys_wr_en),
      .sys_sw_value (sys_sw_value)
   );

   always #5 sys_clk = ~sys_clk;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;
   always @(posedge sys_clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] value;
      int          cycle;
   } exp_t;
   exp_t exp_q[$];

   // Reference model state
   logic [31:0] m_fifo[$];
   logic [31:0] m_shadow = '0;
   logic        m_en = 1'b0;
   logic        m_undr = 1'b0;
   logic        m_ovf = 1'b0;
   logic        m_lost = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] m_stat();
      return {19'b0, m_lost, m_ovf, m_undr, (m_fifo.size() == 0),
              (m_fifo.size() == DEPTH), 8'(m_fifo.size())};
   endfunction

   // Monitor: scheduler writes are matched against the scoreboard, every other
   // cycle the timer bus must carry the CPU access unchanged.
   always @(negedge sys_clk) begin : monitor
      exp_t e;
      if (sys_rst_n) begin
         if (cpu_stall) begin
            if (exp_q.size() == 0) begin
               check("unexpected_sched_write", sys_sw_value, ~sys_sw_value);
            end else begin
               e = exp_q.pop_front();
               check("sched_write_value", sys_sw_value, e.value);
               check("sched_write_cycle", 32'(cyc), 32'(e.cycle));
               check("sched_write_addr", sys_addr, A_MVAL0);
               check("sched_write_en", 32'(sys_wr_en), 32'd1);
            end
         end else begin
            check("fwd_addr", sys_addr, cpu_addr);
            check("fwd_wr_en", 32'(sys_wr_en), 32'(cpu_wr_en));
            check("fwd_data", sys_sw_value, cpu_wr_data);
         end
      end
   end

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic sfr_wr(input logic [31:0] a, input logic [31:0] d);
      cpu_addr    = a;
      cpu_wr_en   = 1'b1;
      cpu_wr_data = d;
      tick();
      cpu_wr_en   = 1'b0;
      cpu_addr    = A_IDLE;
      cpu_wr_data = '0;
   endtask

   task automatic m_push(input logic [31:0] d);
      sfr_wr(A_PUSH, d);
      if (m_fifo.size() < DEPTH) m_fifo.push_back(d);
      else                       m_ovf = 1'b1;
   endtask

   task automatic m_mval0(input logic [31:0] d);
      sfr_wr(A_MVAL0, d);
      m_shadow = d;
   endtask

   // Service one event: the new match value must reach the bus two cycles later.
   task automatic m_service(input int at_cycle);
      if (m_fifo.size() > 0) begin
         m_shadow = m_shadow + m_fifo.pop_front();
         exp_q.push_back('{m_shadow, at_cycle});
      end else begin
         m_undr = 1'b1;
      end
   endtask

   task automatic pulse_event();
      match0_event = 1'b1;
      if (m_en) m_service(cyc + 2);
      tick();
      match0_event = 1'b0;
      repeat (4) tick();
   endtask

   task automatic check_stat(input string name);
      cpu_addr  = A_STAT;
      cpu_wr_en = 1'b0;
      #1;
      check(name, sched_rd_dout, m_stat());
      cpu_addr = A_IDLE;
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : stimulus
      logic [31:0] d;
      logic [7:0]  pat;
      int          s;

      // Reset behaviour
      repeat (3) tick();
      check("rst_stall", 32'(cpu_stall), 32'd0);
      cpu_addr  = 32'h40;
      cpu_wr_en = 1'b1;
      #1;
      check("rst_fwd_wr_en", 32'(sys_wr_en), 32'd1);
      cpu_wr_en = 1'b0;
      cpu_addr  = A_IDLE;
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      tick();
      check_stat("rst_stat");
      cpu_addr = A_CTRL;
      #1;
      check("rst_ctrl", sched_rd_dout, 32'd0);
      cpu_addr = 32'h4;
      #1;
      check("rd_non_sched", sched_rd_dout, 32'd0);
      cpu_addr = A_IDLE;

      // Basic sequence: 100 + 50, 50, 25
      m_mval0(32'd100);
      m_push(32'd50);
      m_push(32'd50);
      m_push(32'd25);
      check_stat("basic_stat_loaded");
      sfr_wr(A_CTRL, 32'h1);
      m_en = 1'b1;
      repeat (3) pulse_event();
      check_stat("basic_stat_drained");

      // Silent wrap of the match value
      m_mval0(32'hFFFF_FFF0);
      m_push(32'h20);
      pulse_event();
      check_stat("wrap_stat");

      // Underflow on an empty queue, then write-1-to-clear
      pulse_event();
      check_stat("undr_set");
      sfr_wr(A_STAT, 32'h400);
      m_undr = 1'b0;
      check_stat("undr_cleared");

      // Overflow: ninth push dropped
      for (int i = 0; i < 9; i++) m_push(32'd1000 + 32'(i));
      check_stat("ovf_full");
      for (int i = 0; i < 9; i++) pulse_event();
      check_stat("ovf_drained_undr");
      sfr_wr(A_STAT, 32'h1C00);
      m_undr = 1'b0;
      m_ovf  = 1'b0;
      check_stat("flags_cleared");

      // Held pulse counts once; then 1,0,1,0,1,0,1 pattern: edge in WRITE
      // pends, edge in POP pends, edge in IDLE with pending set is lost.
      m_push(32'd7);
      m_push(32'd11);
      m_push(32'd13);
      m_push(32'd17);
      match0_event = 1'b1;
      m_service(cyc + 2);
      repeat (5) tick();
      match0_event = 1'b0;
      repeat (2) tick();
      s   = cyc;
      m_service(s + 2);
      m_service(s + 5);
      m_service(s + 8);
      m_lost = 1'b1;
      pat = 8'b0101_0101;
      for (int i = 0; i < 8; i++) begin
         match0_event = pat[i];
         tick();
      end
      match0_event = 1'b0;
      repeat (4) tick();
      check_stat("lost_stat");
      sfr_wr(A_STAT, 32'h1000);
      m_lost = 1'b0;
      check_stat("lost_cleared");

      // CPU write collides with the scheduler bus write
      m_push(32'd5);
      match0_event = 1'b1;
      m_service(cyc + 2);
      tick();
      match0_event = 1'b0;
      tick();
      cpu_addr    = 32'h4;
      cpu_wr_en   = 1'b1;
      cpu_wr_data = 32'hA5A5_0001;
      #1;
      check("stall_high", 32'(cpu_stall), 32'd1);
      check("stall_bus_addr", sys_addr, A_MVAL0);
      tick();
      check("stall_release", 32'(cpu_stall), 32'd0);
      check("repeat_addr", sys_addr, 32'h4);
      check("repeat_data", sys_sw_value, 32'hA5A5_0001);
      check("repeat_wr_en", 32'(sys_wr_en), 32'd1);
      cpu_wr_en   = 1'b0;
      cpu_addr    = A_IDLE;
      cpu_wr_data = '0;
      repeat (2) tick();

      // Clock enable low: a PUSH write has no effect
      sys_clk_en = 1'b0;
      sfr_wr(A_PUSH, 32'h55);
      sys_clk_en = 1'b1;
      check_stat("clk_en_hold");

      // Randomized traffic
      for (int it = 0; it < 250; it++) begin
         case ($urandom_range(0, 5))
            0, 1: m_push($urandom);
            2: pulse_event();
            3: m_mval0($urandom);
            4: sfr_wr(32'h200 + 32'($urandom_range(0, 63)) * 4, $urandom);
            default: begin
               if ($urandom_range(0, 3) == 0) begin
                  sfr_wr(A_CTRL, 32'h3);
                  m_fifo.delete();
               end else begin
                  pulse_event();
               end
            end
         endcase
         if (it % 25 == 24) check_stat("rand_stat");
      end
      repeat (4) tick();
      check_stat("final_stat");
      check("exp_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
